gn_mdl_axis_mst: RTL and testbench

GN_MDL_AXIS_MST -- requirements
Module: gn_mdl_axis_mst

---
 rtl/gn_mdl_axis_mst.sv | 146 ++++++++++++++
 tb/tb_gn_mdl_axis_mst.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gn_mdl_axis_mst.sv
// Buffered AXI-Stream master: load words while idle, then stream N of them out.
// Optional burst throttling is compiled in with `define GN_MDL_AXIS_MST_THROTTLE_EN.
module gn_mdl_axis_mst #(
  parameter int P_DWIDTH     = 32,
  parameter int P_MAX_WORDS  = 256,
  parameter int P_BURST_LEN  = 4,
  parameter int P_GAP_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               wr_en,
  input  logic [$clog2(P_MAX_WORDS)-1:0]     wr_addr,
  input  logic [P_DWIDTH-1:0]                wr_data,
  input  logic                               start,
  input  logic [$clog2(P_MAX_WORDS+1)-1:0]   num_words,
  output logic [P_DWIDTH-1:0]                tx_axis_tdata,
  output logic                               tx_axis_tvalid,
  input  logic                               tx_axis_tready,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(P_MAX_WORDS+1)-1:0]   sent_count
);

  localparam int AW = $clog2(P_MAX_WORDS);
  localparam int CW = $clog2(P_MAX_WORDS + 1);

`ifdef GN_MDL_AXIS_MST_THROTTLE_EN
  localparam int BW = $clog2(P_BURST_LEN + 1);
  localparam int GW = (P_GAP_CYCLES > 1) ? $clog2(P_GAP_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  logic [BW-1:0] r_burst;
  logic [GW-1:0] r_gap;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
`endif

  state_t              r_state;
  logic [P_DWIDTH-1:0] r_mem [P_MAX_WORDS];
  logic [AW-1:0]       r_idx;
  logic [CW-1:0]       r_n;
  logic [CW-1:0]       r_sent;
  logic [P_DWIDTH-1:0] r_tdata;
  logic                r_tvalid;
  logic                r_busy;
  logic                r_done;

  logic [CW-1:0]       w_sent_nxt;
  logic [AW-1:0]       w_idx_nxt;
  logic                w_accept;
  logic                w_wr_ok;

  assign w_sent_nxt = r_sent + 1'b1;
  assign w_idx_nxt  = r_idx + 1'b1;
  assign w_accept   = r_tvalid && tx_axis_tready;
  assign w_wr_ok    = (r_state == S_IDLE) && wr_en && (CW'(wr_addr) < CW'(P_MAX_WORDS));

  // Buffer has no reset so an aborted transfer leaves its contents intact.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_n      <= '0;
      r_sent   <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef GN_MDL_AXIS_MST_THROTTLE_EN
      r_burst  <= '0;
      r_gap    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sent <= '0;
            if (num_words == '0) begin
              r_done <= 1'b1;
            end else begin
              r_n      <= (num_words > CW'(P_MAX_WORDS)) ? CW'(P_MAX_WORDS) : num_words;
              r_idx    <= '0;
              r_tdata  <= r_mem[0];
              r_tvalid <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= S_SEND;
`ifdef GN_MDL_AXIS_MST_THROTTLE_EN
              r_burst  <= '0;
`endif
            end
          end
        end
        S_SEND: begin
          if (w_accept) begin
            r_sent <= w_sent_nxt;
            r_idx  <= w_idx_nxt;
            if (w_sent_nxt == r_n) begin
              r_tvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
`ifdef GN_MDL_AXIS_MST_THROTTLE_EN
              // Gap only after a full burst of non-final beats; next word loads on resume.
              if ((P_GAP_CYCLES > 0) && (r_burst == BW'(P_BURST_LEN - 1))) begin
                r_tvalid <= 1'b0;
                r_burst  <= '0;
                r_gap    <= GW'(P_GAP_CYCLES - 1);
                r_state  <= S_GAP;
              end else begin
                r_burst <= r_burst + 1'b1;
                r_tdata <= r_mem[w_idx_nxt];
              end
`else
              r_tdata <= r_mem[w_idx_nxt];
`endif
            end
          end
        end
`ifdef GN_MDL_AXIS_MST_THROTTLE_EN
        S_GAP: begin
          if (r_gap == '0) begin
            r_tdata  <= r_mem[r_idx];
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_axis_tdata  = r_tdata;
  assign tx_axis_tvalid = r_tvalid;
  assign busy           = r_busy;
  assign done           = r_done;
  assign sent_count     = r_sent;

endmodule

// File: tb/tb_gn_mdl_axis_mst.sv
// Scoreboard bench for gn_mdl_axis_mst: stimulus queues expected beats, a monitor checks them.
module tb_gn_mdl_axis_mst;

  localparam int DW = 32;
  localparam int MW = 256;
  localparam int AW = 8;
  localparam int CW = 9;
  localparam int GAP = 2;
  localparam int BL = 4;
`ifdef GN_MDL_AXIS_MST_THROTTLE_EN
  localparam int THR = 1;
`else
  localparam int THR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_count;

  gn_mdl_axis_mst #(.P_DWIDTH(DW), .P_MAX_WORDS(MW), .P_BURST_LEN(BL), .P_GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .num_words(num_words), .tx_axis_tdata(tdata), .tx_axis_tvalid(tvalid),
    .tx_axis_tready(tready), .busy(busy), .done(done), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int acc_edge[$];
  int acc_cnt = 0;
  logic [DW-1:0] model [MW];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
    end
  endtask

  // Monitor: compares accepted beats against the queue and checks hold-while-stalled.
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (!(tvalid === 1'b1 && tdata === hold_data)) begin
          errors++;
          $display("FAIL stall_hold got tvalid=%b tdata=0x%0h exp tvalid=1 tdata=0x%0h", tvalid, tdata, hold_data);
        end
      end
      if (tvalid === 1'b1 && tready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got=0x%0h exp=none", tdata);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (tdata !== e) begin
            errors++;
            $display("FAIL beat_data got=0x%0h exp=0x%0h", tdata, e);
          end
        end
        acc_edge.push_back(cyc + 1);
        acc_cnt++;
      end
      hold_pend = (tvalid === 1'b1) && (tready === 1'b0);
      hold_data = tdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic start_xfer(input int n, input int nexp);
    for (int i = 0; i < nexp; i++) exp_q.push_back(model[i]);
    acc_edge.delete();
    start = 1'b1; num_words = CW'(n);
    tick();
    start = 1'b0;
  endtask

  function automatic int exp_off(input int i);
    return i + THR * GAP * (i / BL);
  endfunction

  task automatic wait_done(input string nm, output int edge_no);
    edge_no = -1;
    for (int k = 0; k < 500; k++) begin
      if (done === 1'b1) begin
        edge_no = cyc;
        return;
      end
      tick();
    end
    checks++; errors++;
    $display("FAIL %s_timeout got=no_done exp=done", nm);
  endtask

  task automatic check_xfer(input string nm, input int n, input bit spacing);
    int de;
    wait_done(nm, de);
    chk({nm, "_beats"}, acc_edge.size(), n);
    if (acc_edge.size() == n) begin
      chk({nm, "_done_edge"}, de, acc_edge[n-1]);
      if (spacing)
        for (int i = 1; i < n; i++)
          chk($sformatf("%s_spacing%0d", nm, i), acc_edge[i] - acc_edge[0], exp_off(i));
    end
    chk({nm, "_sent"}, sent_count, n);
    chk({nm, "_busy_off"}, busy, 0);
    chk({nm, "_tvalid_off"}, tvalid, 0);
    tick();
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_sent_held"}, sent_count, n);
  endtask

  initial begin
    int base;
    bit seen;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent_count, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) load(i, 32'h10 + 32'(i));

    // Eight beats back-to-back.
    start_xfer(8, 8);
    chk("x8_busy", busy, 1);
    chk("x8_tvalid", tvalid, 1);
    chk("x8_first_tdata", tdata, 32'h10);
    check_xfer("x8", 8, 1'b1);

    // Three beats with a 5-cycle stall on beat 1.
    start_xfer(3, 3);
    base = acc_cnt;
    for (int k = 0; k < 50 && acc_cnt == base; k++) tick();
    chk("x3_first_accepted", acc_cnt - base, 1);
    tready = 1'b0;
    repeat (5) tick();
    chk("x3_stall_tdata", tdata, 32'h11);
    chk("x3_stall_tvalid", tvalid, 1);
    tready = 1'b1;
    check_xfer("x3", 3, 1'b0);

    // Zero-length request.
    start_xfer(0, 0);
    chk("x0_done", done, 1);
    chk("x0_tvalid", tvalid, 0);
    chk("x0_busy", busy, 0);
    chk("x0_sent", sent_count, 0);
    tick();
    chk("x0_done_one_cycle", done, 0);
    chk("x0_no_tvalid", tvalid, 0);

    // Ten beats: gaps after beats 4 and 8 only when throttled.
    start_xfer(10, 10);
    check_xfer("x10", 10, 1'b1);

    // Start and write while busy are ignored.
    start_xfer(4, 4);
    start = 1'b1; num_words = CW'(8);
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hAA;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check_xfer("busy4", 4, 1'b1);
    start_xfer(1, 1);
    check_xfer("after_busy", 1, 1'b0);

    // Reset after beat 2 of 8.
    start_xfer(8, 8);
    base = acc_cnt;
    for (int k = 0; k < 50 && acc_cnt < base + 2; k++) tick();
    chk("rst_mid_two_beats", acc_cnt - base, 2);
    reset_n = 1'b0; tready = 1'b0;
    exp_q.delete();
    tick();
    chk("rst_mid_tvalid", tvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_sent", sent_count, 0);
    seen = done;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      seen = seen | done;
    end
    chk("rst_mid_no_done", seen, 0);
    tready = 1'b1;
    start_xfer(2, 2);
    check_xfer("rst_resend", 2, 1'b1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
